// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (r0 = fetch, r1 = data) arbiter in front of a
// single-port RAM. One transaction is outstanding at a time and is walked
// through IDLE -> ACCESS -> RESP.
// Configuration macro: MEM_ARB_RR_EN
//   defined   : round-robin on contention, the requester not served last wins
//   undefined : fixed priority, r1 always wins contention
// Handshake: a request transfers on a rising edge where rN_valid & rN_ready.
// rN_ready is only ever high in IDLE, for the arbitration winner. The result
// comes back as a single-cycle rN_rvalid pulse with rN_rdata/rN_err.
module mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TMO_CYC = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              r0_valid,
   input  logic              r0_we,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic [DATA_W-1:0] r0_wdata,
   output logic              r0_ready,
   output logic              r0_rvalid,
   output logic [DATA_W-1:0] r0_rdata,
   output logic              r0_err,
   input  logic              r1_valid,
   input  logic              r1_we,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic [DATA_W-1:0] r1_wdata,
   output logic              r1_ready,
   output logic              r1_rvalid,
   output logic [DATA_W-1:0] r1_rdata,
   output logic              r1_err,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic [15:0]       ram_ctrl,
   input  logic [DATA_W-1:0] ram_rdata,
   input  logic              ram_ack,
   output logic              busy,
   output logic [1:0]        dbg_state_o
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_RESP   = 2'd2;

   localparam logic [15:0] TMO_LAST = 16'(TMO_CYC - 1);

   logic [1:0]        state_q, state_d;
   logic [15:0]       cnt_q, cnt_d;
   logic              owner_q, owner_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] r0_rdata_q, r0_rdata_d;
   logic [DATA_W-1:0] r1_rdata_q, r1_rdata_d;
   logic              r0_err_q, r0_err_d;
   logic              r1_err_q, r1_err_d;
   logic              gnt0, gnt1;
   logic              resp_load;
   logic [DATA_W-1:0] resp_rdata;
   logic              resp_err;

`ifdef MEM_ARB_RR_EN
   // Requester served most recently; resets to 1 so r0 wins the first contention.
   logic              last_q, last_d;
`endif

   // Arbitration: only meaningful in IDLE; the winner sees ready combinationally.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (state_q == ST_IDLE) begin
         if (r0_valid && r1_valid) begin
`ifdef MEM_ARB_RR_EN
            gnt0 = last_q;
            gnt1 = !last_q;
`else
            gnt1 = 1'b1;
`endif
         end else begin
            gnt0 = r0_valid;
            gnt1 = r1_valid;
         end
      end
   end

   // ACCESS completion: an ack beats a same-cycle timeout; writes return zero data.
   always_comb begin
      resp_load  = 1'b0;
      resp_rdata = '0;
      resp_err   = 1'b0;
      if (state_q == ST_ACCESS) begin
         if (ram_ack) begin
            resp_load  = 1'b1;
            resp_rdata = we_q ? '0 : ram_rdata;
            resp_err   = 1'b0;
         end else if (cnt_q == TMO_LAST) begin
            resp_load  = 1'b1;
            resp_rdata = '0;
            resp_err   = 1'b1;
         end
      end
   end

   // Next-state logic for the transaction FSM and its latches.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      owner_d    = owner_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      r0_rdata_d = r0_rdata_q;
      r1_rdata_d = r1_rdata_q;
      r0_err_d   = r0_err_q;
      r1_err_d   = r1_err_q;
`ifdef MEM_ARB_RR_EN
      last_d     = last_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (gnt0 || gnt1) begin
               state_d = ST_ACCESS;
               cnt_d   = '0;
               owner_d = gnt1;
               we_d    = gnt1 ? r1_we    : r0_we;
               addr_d  = gnt1 ? r1_addr  : r0_addr;
               wdata_d = gnt1 ? r1_wdata : r0_wdata;
`ifdef MEM_ARB_RR_EN
               last_d  = gnt1;
`endif
            end
         end
         ST_ACCESS: begin
            if (resp_load) begin
               state_d = ST_RESP;
               if (owner_q) begin
                  r1_rdata_d = resp_rdata;
                  r1_err_d   = resp_err;
               end else begin
                  r0_rdata_d = resp_rdata;
                  r0_err_d   = resp_err;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and latch registers; reset drops any in-flight transaction.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         owner_q    <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         r0_rdata_q <= '0;
         r1_rdata_q <= '0;
         r0_err_q   <= 1'b0;
         r1_err_q   <= 1'b0;
`ifdef MEM_ARB_RR_EN
         last_q     <= 1'b1;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         owner_q    <= owner_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         r0_rdata_q <= r0_rdata_d;
         r1_rdata_q <= r1_rdata_d;
         r0_err_q   <= r0_err_d;
         r1_err_q   <= r1_err_d;
`ifdef MEM_ARB_RR_EN
         last_q     <= last_d;
`endif
      end
   end

   // Output decode: strobes only in ACCESS, rvalid only in RESP for the owner.
   always_comb begin
      r0_ready    = gnt0;
      r1_ready    = gnt1;
      r0_rvalid   = (state_q == ST_RESP) && !owner_q;
      r1_rvalid   = (state_q == ST_RESP) && owner_q;
      r0_rdata    = r0_rdata_q;
      r1_rdata    = r1_rdata_q;
      r0_err      = r0_err_q;
      r1_err      = r1_err_q;
      ram_addr    = addr_q;
      ram_wdata   = wdata_q;
      ram_ctrl    = (state_q == ST_ACCESS) ? {14'b0, we_q, !we_q} : 16'h0000;
      busy        = (state_q != ST_IDLE);
      dbg_state_o = state_q;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset values, read, write with late ack,
// timeout, contention ordering and reset in the middle of an access.
module tb_mem_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TMO_CYC = 16;

  logic              clk;
  logic              rst;
  logic              r0_valid, r0_we, r0_ready, r0_rvalid, r0_err;
  logic [ADDR_W-1:0] r0_addr;
  logic [DATA_W-1:0] r0_wdata, r0_rdata;
  logic              r1_valid, r1_we, r1_ready, r1_rvalid, r1_err;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r1_wdata, r1_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;
  logic [15:0]       ram_ctrl;
  logic              ram_ack;
  logic              busy;
  logic [1:0]        dbg_state;

  int n_checks;
  int n_fail;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TMO_CYC(TMO_CYC)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ready(r0_ready), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata), .r0_err(r0_err),
    .r1_valid(r1_valid), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ready(r1_ready), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata), .r1_err(r1_err),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_ctrl(ram_ctrl),
    .ram_rdata(ram_rdata), .ram_ack(ram_ack), .busy(busy), .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    r0_valid = 0; r0_we = 0; r0_addr = '0; r0_wdata = '0;
    r1_valid = 0; r1_we = 0; r1_addr = '0; r1_wdata = '0;
    ram_rdata = '0; ram_ack = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 0;
    step(); step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %h exp 0", busy); end
    n_checks++; if (ram_ctrl !== 16'h0) begin n_fail++; $display("FAIL reset_ctrl got %h exp 0", ram_ctrl); end
    n_checks++; if (ram_addr !== '0) begin n_fail++; $display("FAIL reset_addr got %h exp 0", ram_addr); end
    n_checks++; if (ram_wdata !== '0) begin n_fail++; $display("FAIL reset_wdata got %h exp 0", ram_wdata); end
    n_checks++; if ({r0_rvalid, r1_rvalid, r0_err, r1_err} !== 4'b0) begin n_fail++; $display("FAIL reset_flags got %b exp 0000", {r0_rvalid, r1_rvalid, r0_err, r1_err}); end
    n_checks++; if (r0_rdata !== '0 || r1_rdata !== '0) begin n_fail++; $display("FAIL reset_rdata got %h/%h exp 0/0", r0_rdata, r1_rdata); end
    rst = 1;
    step();
    n_checks++; if ({r0_ready, r1_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready got %b exp 00", {r0_ready, r1_ready}); end
  endtask

  // r0 read, ack in first ACCESS cycle
  task automatic test_read();
    r0_valid = 1; r0_we = 0; r0_addr = 32'h100;
    #1;
    n_checks++; if ({r0_ready, r1_ready} !== 2'b10) begin n_fail++; $display("FAIL rd_ready got %b exp 10", {r0_ready, r1_ready}); end
    step();
    r0_valid = 0;
    n_checks++; if (ram_ctrl !== 16'h0001) begin n_fail++; $display("FAIL rd_ctrl got %h exp 0001", ram_ctrl); end
    n_checks++; if (ram_addr !== 32'h100) begin n_fail++; $display("FAIL rd_addr got %h exp 100", ram_addr); end
    n_checks++; if (busy !== 1'b1 || r0_ready !== 1'b0) begin n_fail++; $display("FAIL rd_busy got %b%b exp 10", busy, r0_ready); end
    ram_ack = 1; ram_rdata = 32'hDEADBEEF;
    step();
    ram_ack = 0; ram_rdata = '0;
    n_checks++; if (r0_rvalid !== 1'b1 || r1_rvalid !== 1'b0) begin n_fail++; $display("FAIL rd_rvalid got %b%b exp 10", r0_rvalid, r1_rvalid); end
    n_checks++; if (r0_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_rdata got %h exp deadbeef", r0_rdata); end
    n_checks++; if (r0_err !== 1'b0) begin n_fail++; $display("FAIL rd_err got %b exp 0", r0_err); end
    n_checks++; if (ram_ctrl !== 16'h0) begin n_fail++; $display("FAIL rd_ctrl_resp got %h exp 0", ram_ctrl); end
    step();
    n_checks++; if (r0_rvalid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rd_after got %b%b exp 00", r0_rvalid, busy); end
    n_checks++; if (r0_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_hold got %h exp deadbeef", r0_rdata); end
  endtask

  // r1 write, ack in the third ACCESS cycle
  task automatic test_write();
    r1_valid = 1; r1_we = 1; r1_addr = 32'h200; r1_wdata = 32'h12345678;
    #1;
    n_checks++; if ({r0_ready, r1_ready} !== 2'b01) begin n_fail++; $display("FAIL wr_ready got %b exp 01", {r0_ready, r1_ready}); end
    step();
    r1_valid = 0;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (ram_ctrl !== 16'h0002 || ram_wdata !== 32'h12345678 || ram_addr !== 32'h200) begin
        n_fail++; $display("FAIL wr_access%0d got %h/%h/%h exp 0002/12345678/200", i, ram_ctrl, ram_wdata, ram_addr);
      end
      if (i == 2) begin ram_ack = 1; ram_rdata = 32'hFFFF0000; end
      step();
    end
    ram_ack = 0; ram_rdata = '0;
    n_checks++; if (r1_rvalid !== 1'b1 || r0_rvalid !== 1'b0) begin n_fail++; $display("FAIL wr_rvalid got %b%b exp 01", r0_rvalid, r1_rvalid); end
    n_checks++; if (r1_rdata !== '0 || r1_err !== 1'b0) begin n_fail++; $display("FAIL wr_resp got %h/%b exp 0/0", r1_rdata, r1_err); end
    step();
  endtask

  // r0 read with no ack: timeout after TMO_CYC ACCESS cycles
  task automatic test_timeout();
    int acc;
    r0_valid = 1; r0_we = 0; r0_addr = 32'h300;
    step();
    r0_valid = 0;
    acc = 0;
    for (int i = 0; i < 40 && r0_rvalid !== 1'b1; i++) begin
      if (ram_ctrl == 16'h0001) acc++;
      step();
    end
    n_checks++; if (acc != TMO_CYC) begin n_fail++; $display("FAIL tmo_cycles got %0d exp %0d", acc, TMO_CYC); end
    n_checks++; if (r0_rvalid !== 1'b1 || r0_err !== 1'b1) begin n_fail++; $display("FAIL tmo_flags got %b%b exp 11", r0_rvalid, r0_err); end
    n_checks++; if (r0_rdata !== '0) begin n_fail++; $display("FAIL tmo_rdata got %h exp 0", r0_rdata); end
    // a stray ack outside ACCESS must do nothing
    ram_ack = 1; ram_rdata = 32'hBAD0BAD0;
    step(); step();
    n_checks++; if (busy !== 1'b0 || r0_rvalid !== 1'b0 || r0_rdata !== '0 || r0_err !== 1'b1) begin
      n_fail++; $display("FAIL tmo_stray got %b%b/%h/%b exp 00/0/1", busy, r0_rvalid, r0_rdata, r0_err);
    end
    ram_ack = 0; ram_rdata = '0;
  endtask

  // both requesters valid continuously; starts from reset for a known pointer
  task automatic test_contention();
    logic [3:0] exp_w;
    logic       w;
`ifdef MEM_ARB_RR_EN
    exp_w = 4'b1010; // bit k = grant of transaction k (0 = r0)
`else
    exp_w = 4'b1111;
`endif
    rst = 0; step(); rst = 1; step();
    r0_valid = 1; r0_we = 0; r0_addr = 32'h10;
    r1_valid = 1; r1_we = 0; r1_addr = 32'h20;
    #1;
    for (int k = 0; k < 4; k++) begin
      w = r1_ready;
      n_checks++; if ((r0_ready ^ r1_ready) !== 1'b1 || w !== exp_w[k]) begin
        n_fail++; $display("FAIL cont_grant%0d got %b%b exp winner r%0d", k, r0_ready, r1_ready, exp_w[k]);
      end
      step();
      ram_ack = 1; ram_rdata = 32'hA0000000 + 32'(k);
      step();
      ram_ack = 0; ram_rdata = '0;
      n_checks++; if ((w ? r1_rvalid : r0_rvalid) !== 1'b1 || (w ? r1_rdata : r0_rdata) !== 32'hA0000000 + 32'(k)) begin
        n_fail++; $display("FAIL cont_resp%0d got %b%b/%h exp data %h", k, r0_rvalid, r1_rvalid, (w ? r1_rdata : r0_rdata), 32'hA0000000 + 32'(k));
      end
      step();
    end
    r0_valid = 0; r1_valid = 0;
    step();
  endtask

  // reset asserted in the second ACCESS cycle
  task automatic test_reset_mid();
    int seen;
    r0_valid = 1; r0_we = 0; r0_addr = 32'h500;
    step();
    r0_valid = 0;
    step();
    n_checks++; if (ram_ctrl !== 16'h0001) begin n_fail++; $display("FAIL rm_pre got %h exp 0001", ram_ctrl); end
    rst = 0;
    #1;
    n_checks++; if (ram_ctrl !== 16'h0 || busy !== 1'b0 || ram_addr !== '0) begin
      n_fail++; $display("FAIL rm_async got %h/%b/%h exp 0/0/0", ram_ctrl, busy, ram_addr);
    end
    step();
    rst = 1;
    ram_ack = 1; ram_rdata = 32'h77777777;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      ram_ack = 0;
      if (r0_rvalid || r1_rvalid || busy) seen++;
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL rm_ghost got %0d exp 0", seen); end
    r1_valid = 1; r1_we = 0; r1_addr = 32'h400;
    #1;
    n_checks++; if (r1_ready !== 1'b1) begin n_fail++; $display("FAIL rm_ready got %b exp 1", r1_ready); end
    step();
    r1_valid = 0;
    ram_ack = 1; ram_rdata = 32'h55AA55AA;
    step();
    ram_ack = 0; ram_rdata = '0;
    n_checks++; if (r1_rvalid !== 1'b1 || r1_rdata !== 32'h55AA55AA || r1_err !== 1'b0) begin
      n_fail++; $display("FAIL rm_after got %b/%h/%b exp 1/55aa55aa/0", r1_rvalid, r1_rdata, r1_err);
    end
    step();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 0;
    idle_inputs();
    #1;
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_contention();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // time limit guard
  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: address width, all address ports.
REQ-002 Parameter DATA_W, default 32: data width, all data ports.
REQ-003 Parameter TMO_CYC, default 16: maximum ACCESS-state cycles before timeout; legal range 2..65535.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 rN_valid  input  1  requester N (N=0 fetch, N=1 data) has a request.
REQ-007 rN_we  input  1  requester N request is a write (1) or read (0).
REQ-008 rN_addr  input  ADDR_W  requester N address.
REQ-009 rN_wdata  input  DATA_W  requester N write data.
REQ-010 rN_ready  output  1  request N accepted on this rising edge.
REQ-011 rN_rvalid  output  1  one-cycle completion pulse to requester N.
REQ-012 rN_rdata  output  DATA_W  read data, valid with rN_rvalid.
REQ-013 rN_err  output  1  timeout flag, valid with rN_rvalid.
REQ-014 ram_addr  output  ADDR_W  address to RAM.
REQ-015 ram_wdata  output  DATA_W  write data to RAM.
REQ-016 ram_ctrl  output  16  RAM control: bit0 read strobe, bit1 write strobe, bits 15:2 always 0.
REQ-017 ram_rdata  input  DATA_W  RAM read data, sampled on ram_ack.
REQ-018 ram_ack  input  1  RAM completed current access.
REQ-019 busy  output  1  high whenever state is not IDLE.

Function
REQ-020 FSM states IDLE, ACCESS, RESP; one outstanding transaction at a time.
REQ-021 IDLE: rN_ready driven combinationally high for the arbitration winner only; all rN_ready low in ACCESS and RESP.
REQ-022 Accept on edge where rN_valid&rN_ready: latch addr, wdata, we, owner id; go ACCESS; counter cleared to 0.
REQ-023 Requester holds valid/we/addr/wdata stable until ready; deasserting valid before ready withdraws the request without effect.
REQ-024 ACCESS: ram_addr/ram_wdata from latches; ram_ctrl bit0 = !we, bit1 = we; counter increments each cycle.
REQ-025 ACCESS with ram_ack=1: capture ram_rdata (reads), err=0, go RESP.
REQ-026 ACCESS with ram_ack=0 and counter = TMO_CYC-1: err=1, rdata=0, go RESP.
REQ-027 ram_ack and timeout in the same cycle: ack wins, err=0.
REQ-028 RESP: owner's rN_rvalid high exactly one cycle with rN_rdata/rN_err; writes return rdata=0; next state IDLE.
REQ-029 Latency: ack in first ACCESS cycle gives rvalid 2 cycles after acceptance edge; new request accepted no earlier than cycle after RESP.
REQ-030 ram_ctrl=0 in IDLE and RESP; ram_ack outside ACCESS ignored.
REQ-031 rN_rdata/rN_err hold last values between pulses; non-owner rvalid stays 0.

Reset
REQ-032 rst low asynchronously forces: state IDLE, counter 0, ram_ctrl 0, ram_addr 0, ram_wdata 0, all rN_rvalid/rN_err 0, rN_rdata 0, busy 0, RR pointer to 1.
REQ-033 Reset during ACCESS/RESP drops the transaction; no rvalid is issued for it after release.

Configuration
REQ-034 Macro MEM_ARB_RR_EN defined: round-robin; on contention the requester not served last wins; pointer reset 1, so r0 wins first contention.
REQ-035 Macro undefined: fixed priority, r1 always wins contention; no pointer register.

Verification
REQ-036 r0 read addr 0x100, ram_ack in first ACCESS cycle, ram_rdata 0xDEADBEEF -> r0_rvalid 2 cycles after accept, r0_rdata 0xDEADBEEF, r0_err 0, ram_ctrl 0x0001 during ACCESS.
REQ-037 r1 write addr 0x200 data 0x12345678, ack after 3 cycles -> ram_ctrl 0x0002, ram_wdata 0x12345678 held 3 cycles, r1_rvalid with rdata 0.
REQ-038 r0 read, ram_ack never, TMO_CYC=16 -> r0_rvalid exactly 16 ACCESS cycles after accept, r0_err 1, rdata 0.
REQ-039 r0 and r1 valid continuously, 4 transactions -> RR build: grants r0,r1,r0,r1; fixed build: r1,r1,r1,r1.
REQ-040 rst low in 2nd ACCESS cycle -> ram_ctrl 0 immediately, busy 0, no rvalid after release, next request serviced normally.
